// File: rtl/pc_npc_sequencer_pkg.sv
// Shared fetch-sequencer definitions: instruction size, SPARC opcode
// fields, default reset vector and the fetch-state encoding.
package pc_npc_sequencer_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned RESET_VECTOR = 0;

    // SPARC op field (inst[31:30])
    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM = 2'b11;

    // op2 (format 2) and op3 (format 3) values for CTIs
    localparam logic [2:0] OP2_BICC = 3'b010;
    localparam logic [5:0] OP3_JMPL = 6'h38;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_npc_sequencer_incrementer.sv
// pc_incrementer: combinational addr + INSTR_BYTES, modulo 2^ADDR_W.
// Ports: addr (in, ADDR_W), sum (out, ADDR_W).
module pc_incrementer
    import pc_npc_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] sum
);

    assign sum = addr + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/pc_npc_sequencer.sv
// PC/nPC fetch sequencer with SPARC delayed-branch semantics.
// Ports: Clk, R (async high reset), LE (advance enable), cti_taken,
//   cti_target, annul_slot in; PC, nPC, fetch_valid, fetch_count,
//   trap_misalign out. Build option: MISALIGN_TRAP_EN.
module pc_npc_sequencer
    import pc_npc_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR),
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              R,
    input  logic              LE,
    input  logic              cti_taken,
    input  logic [ADDR_W-1:0] cti_target,
    input  logic              annul_slot,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] nPC,
    output logic              fetch_valid,
    output logic [CNT_W-1:0]  fetch_count,
    output logic              trap_misalign
);

    localparam logic [ADDR_W-1:0] RESET_NPC =
        RESET_PC + ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] npc_q;
    logic [ADDR_W-1:0] npc_d;
    logic [ADDR_W-1:0] npc_inc;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt_q;
    logic              redirect;
    logic              misalign;
    fetch_state_t      state_q;
    fetch_state_t      state_d;

    pc_incrementer #(
        .ADDR_W(ADDR_W)
    ) u_inc (
        .addr(npc_q),
        .sum (npc_inc)
    );

`ifdef MISALIGN_TRAP_EN
    // Misaligned target: trap and fall through sequentially.
    assign misalign = cti_taken && (cti_target[1:0] != 2'b00);
    assign redirect = cti_taken && !misalign;
    assign target   = cti_target;
`else
    // Low bits dropped so the fetch address is always word aligned.
    assign misalign = 1'b0;
    assign redirect = cti_taken;
    assign target   = cti_target & ~ADDR_W'(3);
`endif

    always_comb begin
        npc_d = npc_inc;
        unique case (1'b1)
            redirect: npc_d = target;
            default:  npc_d = npc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (LE) begin
            state_d = annul_slot ? SQUASH : RUN;
        end
    end

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_NPC;
            cnt_q <= '0;
        end else if (LE) begin
            pc_q  <= npc_q;
            npc_q <= npc_d;
            // Count the fetch being retired from PC, if it was valid.
            if (state_q == RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= LE && misalign;
        end
    end

    assign trap_misalign = trap_q;
`else
    assign trap_misalign = misalign;
`endif

    assign PC          = pc_q;
    assign nPC         = npc_q;
    assign fetch_valid = (state_q == RUN);
    assign fetch_count = cnt_q;

endmodule
